exc_commit_ctrl: RTL

EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

---
 rtl/exc_commit_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit sequencer: walks the CP0 updates (EPC, BadVAddr,
// Cause, Status) one write per cycle, then flushes and redirects fetch.
module exc_commit_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc_in,
  input  logic [31:0] badvaddr_in,
  input  logic        in_delay_slot,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        stall_req,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_BADV  = 3'd2,
    W_CAUSE = 3'd3,
    W_STAT  = 3'd4,
    REDIR   = 3'd5
  } state_t;

  localparam logic [4:0]  CODE_ADEL  = 5'h04;
  localparam logic [4:0]  CODE_ADES  = 5'h05;
  localparam logic [4:0]  CODE_ERET  = 5'h1f;
  localparam logic [4:0]  ADDR_BADV  = 5'd8;
  localparam logic [4:0]  ADDR_STAT  = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [31:0] EXC_VEC    = 32'hbfc0_0380;

  state_t      state;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic [31:0] badv_q;
  logic        bd_q;
  logic        exl_q;
  logic        is_eret;
  logic        bd_next;
  logic        unused_cause;

  assign is_eret      = (code_q == CODE_ERET);
  // Cause.ExcCode is overwritten, so the incoming field is never read
  assign unused_cause = ^cp0_cause[6:2];
  // A nested exception keeps the original Cause.BD along with the original EPC
  assign bd_next      = exl_q ? cp0_cause[31] : bd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      code_q <= '0;
      pc_q   <= '0;
      badv_q <= '0;
      bd_q   <= 1'b0;
      exl_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (exc_valid) begin
          code_q <= exc_code;
          pc_q   <= pc_in;
          badv_q <= badvaddr_in;
          bd_q   <= in_delay_slot;
          exl_q  <= cp0_status[1];
          state  <= (exc_code == CODE_ERET) ? W_STAT : W_EPC;
        end
        W_EPC:   state <= (code_q == CODE_ADEL || code_q == CODE_ADES) ? W_BADV : W_CAUSE;
        W_BADV:  state <= W_CAUSE;
        W_CAUSE: state <= W_STAT;
        W_STAT:  state <= REDIR;
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy | (exc_valid & resetn);

  always_comb begin
    cp0_we         = 1'b0;
    cp0_waddr      = '0;
    cp0_wdata      = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      W_EPC: if (!exl_q) begin
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_EPC;
        cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
      end
      W_BADV: begin
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_BADV;
        cp0_wdata = badv_q;
      end
      W_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_CAUSE;
        cp0_wdata = {bd_next, cp0_cause[30:7], code_q, cp0_cause[1:0]};
      end
      W_STAT: begin
        cp0_we    = 1'b1;
        cp0_waddr = ADDR_STAT;
        cp0_wdata = {cp0_status[31:2], ~is_eret, cp0_status[0]};
      end
      REDIR: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = is_eret ? cp0_epc : EXC_VEC;
      end
      default: ;
    endcase
  end

endmodule
